// File: rtl/spi_slave_buffered.sv
// SPI mode-0 responder with a host-preloaded Tx buffer and an Rx capture buffer.
// All SPI pins are oversampled and edge-detected in the sysClk domain.
module spi_slave_buffered #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int ADDR_WIDTH  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  sysClk,
    input  logic                  reset,
    input  logic                  spiClk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [ADDR_WIDTH-1:0] tx_addr,
    input  logic [DATA_WIDTH-1:0] tx_byte,
    input  logic                  tx_wr,
    input  logic [ADDR_WIDTH-1:0] rx_addr,
    input  logic                  rx_rd,
    output logic [DATA_WIDTH-1:0] rx_byte,
    output logic [ADDR_WIDTH:0]   rx_count,
    output logic                  busy,
    output logic                  trx_done
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_BIT_C = CNT_W'(DATA_WIDTH-1);

    typedef enum logic [1:0] {SIdle = 2'd0, SShift = 2'd1, SDone = 2'd2} state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                    sclk_prev_q, cs_prev_q;
    logic                    sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s, mosi_s;
    logic                    miso_q, miso_d, busy_q, busy_d, trx_done_q, trx_done_d;
    logic [DATA_WIDTH-1:0]   rx_byte_q, rx_byte_d, tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic [ADDR_WIDTH:0]     rx_count_q, rx_count_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [ADDR_WIDTH-1:0]   byte_idx_q, byte_idx_d;
    logic [DATA_WIDTH-1:0]   tx_buf_q [DEPTH];
    logic [DATA_WIDTH-1:0]   tx_buf_d [DEPTH];
    logic [DATA_WIDTH-1:0]   rx_buf_q [DEPTH];
    logic [DATA_WIDTH-1:0]   rx_buf_d [DEPTH];

    // Synchronizers clear to 0 so that a cs held low across reset cannot look like a fresh fall.
    always_ff @(posedge sysClk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spiClk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_rise_s = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign sclk_fall_s = ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
    assign cs_rise_s   = cs_sync_q[SYNC_STAGES-1] & ~cs_prev_q;
    assign cs_fall_s   = ~cs_sync_q[SYNC_STAGES-1] & cs_prev_q;
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];

    // Next-state logic for the FSM, shift registers, counters and both buffers.
    always_comb begin
        state_d    = state_q;
        miso_d     = miso_q;
        busy_d     = busy_q;
        trx_done_d = 1'b0;
        rx_count_d = rx_count_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        tx_buf_d   = tx_buf_q;
        rx_buf_d   = rx_buf_q;

        if (!tx_wr && !busy_q) begin
            tx_buf_d[tx_addr] = tx_byte;
        end else begin
            tx_buf_d = tx_buf_q;
        end

        if (!rx_rd) begin
            rx_byte_d = rx_buf_q[rx_addr];
        end else begin
            rx_byte_d = rx_byte_q;
        end

        case (state_q)
            SIdle: begin
                if (cs_fall_s) begin
                    state_d    = SShift;
                    busy_d     = 1'b1;
                    rx_count_d = '0;
                    bit_cnt_d  = '0;
                    byte_idx_d = '0;
                    tx_shift_d = tx_buf_q[0];
                    miso_d     = tx_buf_q[0][DATA_WIDTH-1];
                end else begin
                    state_d = SIdle;
                end
            end
            SShift: begin
                // A cs rise outranks any spiClk edge seen in the same cycle.
                if (cs_rise_s) begin
                    state_d    = SDone;
                    trx_done_d = 1'b1;
                end else if (sclk_rise_s) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                    if (bit_cnt_q == LAST_BIT_C) begin
                        rx_buf_d[byte_idx_q] = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                        byte_idx_d = byte_idx_q + ADDR_WIDTH'(1);
                        bit_cnt_d  = '0;
                        if (rx_count_q == DEPTH_C) begin
                            rx_count_d = rx_count_q;
                        end else begin
                            rx_count_d = rx_count_q + (ADDR_WIDTH+1)'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall_s) begin
                    if (bit_cnt_q == '0 && rx_count_q != '0) begin
                        tx_shift_d = tx_buf_q[byte_idx_q];
                        miso_d     = tx_buf_q[byte_idx_q][DATA_WIDTH-1];
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                        miso_d     = tx_shift_q[DATA_WIDTH-2];
                    end
                end else begin
                    state_d = SShift;
                end
            end
            SDone: begin
                busy_d  = 1'b0;
                miso_d  = 1'b0;
                state_d = SIdle;
            end
            default: begin
                state_d = SIdle;
            end
        endcase
    end

    // State and datapath registers; reset wipes the buffers as well.
    always_ff @(posedge sysClk) begin
        if (reset) begin
            state_q    <= SIdle;
            miso_q     <= 1'b0;
            busy_q     <= 1'b0;
            trx_done_q <= 1'b0;
            rx_byte_q  <= '0;
            rx_count_q <= '0;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tx_buf_q[i] <= '0;
                rx_buf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            miso_q     <= miso_d;
            busy_q     <= busy_d;
            trx_done_q <= trx_done_d;
            rx_byte_q  <= rx_byte_d;
            rx_count_q <= rx_count_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            tx_buf_q   <= tx_buf_d;
            rx_buf_q   <= rx_buf_d;
        end
    end

    assign miso     = miso_q;
    assign busy     = busy_q;
    assign trx_done = trx_done_q;
    assign rx_byte  = rx_byte_q;
    assign rx_count = rx_count_q;

endmodule

// File: tb/tb_spi_slave_buffered.sv
// Scoreboard bench for spi_slave_buffered: a mode-0 master task plus a negedge monitor.
module tb_spi_slave_buffered;

    localparam int HALF = 8;

    logic       sysClk = 1'b0;
    logic       reset, spiClk, cs, mosi, miso, tx_wr, rx_rd, busy, trx_done;
    logic [1:0] tx_addr, rx_addr;
    logic [7:0] tx_byte, rx_byte;
    logic [2:0] rx_count;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_miso_q[$], got_miso_q[$], exp_rx_q[$];
    logic [2:0] exp_cnt_q[$];
    logic       rd_d1 = 1'b0;

    spi_slave_buffered dut (
        .sysClk(sysClk), .reset(reset), .spiClk(spiClk), .cs(cs), .mosi(mosi), .miso(miso),
        .tx_addr(tx_addr), .tx_byte(tx_byte), .tx_wr(tx_wr), .rx_addr(rx_addr), .rx_rd(rx_rd),
        .rx_byte(rx_byte), .rx_count(rx_count), .busy(busy), .trx_done(trx_done)
    );

    always #5 sysClk = ~sysClk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge sysClk);
        #1;
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues as they appear.
    always @(negedge sysClk) begin
        if (!reset && trx_done) begin
            if (exp_cnt_q.size() == 0) check("trx_done_unexpected", int'(trx_done), 0);
            else check("rx_count", int'(rx_count), int'(exp_cnt_q.pop_front()));
        end
        if (rd_d1) begin
            if (exp_rx_q.size() == 0) check("rx_read_unexpected", 1, 0);
            else check("rx_byte", int'(rx_byte), int'(exp_rx_q.pop_front()));
        end
        rd_d1 = !rx_rd && !reset;
        while (got_miso_q.size() > 0) begin
            if (exp_miso_q.size() == 0) check("miso_byte_unexpected", int'(got_miso_q.pop_front()), 0);
            else check("miso_byte", int'(got_miso_q.pop_front()), int'(exp_miso_q.pop_front()));
        end
    end

    task automatic preload(input logic [1:0] a, input logic [7:0] d);
        tx_wr = 1'b0; tx_addr = a; tx_byte = d;
        cyc(1);
        tx_wr = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] e);
        exp_rx_q.push_back(e);
        rx_rd = 1'b0; rx_addr = a;
        cyc(1);
        rx_rd = 1'b1;
        cyc(1);
    endtask

    // Mode-0 master: bits taken MSB-first from data[39]; optional mid-transfer tx_wr or trailing reset.
    task automatic spi_xfer(input logic [39:0] data, input int nbits, input int wr_at_bit, input bit rst_at_end);
        logic [7:0] got = 8'h00;
        cs = 1'b0;
        cyc(HALF);
        for (int i = 0; i < nbits; i++) begin
            mosi = data[39-i];
            if (i == wr_at_bit) begin
                tx_wr = 1'b0; tx_addr = 2'd0; tx_byte = 8'hEE;
                cyc(1);
                tx_wr = 1'b1;
                cyc(HALF-1);
            end else begin
                cyc(HALF);
            end
            if (i == 4) check("busy_mid", int'(busy), 1);
            spiClk = 1'b1;
            got = {got[6:0], miso};
            if (i % 8 == 7) got_miso_q.push_back(got);
            cyc(HALF);
            spiClk = 1'b0;
        end
        cyc(HALF);
        if (rst_at_end) begin
            reset = 1'b1;
            cyc(1);
            check("rst_mid_outputs", int'({miso, rx_byte, rx_count, busy, trx_done}), 0);
            reset = 1'b0;
            cs = 1'b1;
            cyc(20);
        end else begin
            cs = 1'b1;
            cyc(20);
            check("busy_after", int'(busy), 0);
            check("miso_idle", int'(miso), 0);
        end
    endtask

    initial begin
        reset = 1'b1; spiClk = 1'b0; cs = 1'b1; mosi = 1'b0;
        tx_wr = 1'b1; tx_addr = 2'd0; tx_byte = 8'h00; rx_rd = 1'b1; rx_addr = 2'd0;
        cyc(1);
        // 1: reset with random inputs
        for (int i = 0; i < 2; i++) begin
            spiClk = 1'($urandom); cs = 1'($urandom); mosi = 1'($urandom);
            tx_wr = 1'($urandom); tx_addr = 2'($urandom); tx_byte = 8'($urandom);
            rx_rd = 1'($urandom); rx_addr = 2'($urandom);
            cyc(1);
        end
        reset = 1'b0; spiClk = 1'b0; cs = 1'b1; mosi = 1'b0; tx_wr = 1'b1; rx_rd = 1'b1;
        check("reset_outputs", int'({miso, rx_byte, rx_count, busy, trx_done}), 0);
        cyc(4);
        for (int a = 0; a < 4; a++) rd(2'(a), 8'h00);

        // 2: single byte
        preload(2'd0, 8'hA5);
        exp_miso_q.push_back(8'hA5); exp_cnt_q.push_back(3'd1);
        spi_xfer({8'h41, 32'h0}, 8, -1, 1'b0);
        rd(2'd0, 8'h41);

        // 3: full buffer
        preload(2'd0, 8'h11); preload(2'd1, 8'h22); preload(2'd2, 8'h33); preload(2'd3, 8'h44);
        exp_miso_q.push_back(8'h11); exp_miso_q.push_back(8'h22);
        exp_miso_q.push_back(8'h33); exp_miso_q.push_back(8'h44);
        exp_cnt_q.push_back(3'd4);
        spi_xfer({32'h410F007E, 8'h00}, 32, -1, 1'b0);
        rd(2'd0, 8'h41); rd(2'd1, 8'h0F); rd(2'd2, 8'h00); rd(2'd3, 8'h7E);

        // 4: wrap with five bytes
        exp_miso_q.push_back(8'h11); exp_miso_q.push_back(8'h22); exp_miso_q.push_back(8'h33);
        exp_miso_q.push_back(8'h44); exp_miso_q.push_back(8'h11);
        exp_cnt_q.push_back(3'd4);
        spi_xfer(40'h0102030405, 40, -1, 1'b0);
        rd(2'd0, 8'h05); rd(2'd1, 8'h02); rd(2'd2, 8'h03); rd(2'd3, 8'h04);

        // 5: partial byte plus blocked Tx write
        exp_miso_q.push_back(8'h11); exp_cnt_q.push_back(3'd1);
        spi_xfer({8'hC3, 8'hB0, 24'h0}, 13, 3, 1'b0);
        rd(2'd0, 8'hC3); rd(2'd1, 8'h02);
        exp_miso_q.push_back(8'h11); exp_cnt_q.push_back(3'd1);
        spi_xfer({8'h3C, 32'h0}, 8, -1, 1'b0);
        rd(2'd0, 8'h3C);

        // 6: reset after 12 bits, then a clean transaction
        exp_miso_q.push_back(8'h11);
        spi_xfer({8'hAB, 8'hC0, 24'h0}, 12, -1, 1'b1);
        rd(2'd0, 8'h00);
        preload(2'd0, 8'h5A);
        exp_miso_q.push_back(8'h5A); exp_cnt_q.push_back(3'd1);
        spi_xfer({8'h96, 32'h0}, 8, -1, 1'b0);
        rd(2'd0, 8'h96); rd(2'd1, 8'h00);

        cyc(10);
        check("pending_trx_done", exp_cnt_q.size(), 0);
        check("pending_rx_reads", exp_rx_q.size(), 0);
        check("pending_miso_bytes", exp_miso_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
